// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared constants, glyphs and buffer entry type for seg_scan_driver
// Contents: segment-bus constants, active-low glyph table entries, buffer entry struct,
//           decimal-point overlay helper.
package seg_scan_driver_pkg;

  // Segment bus encoding: bit 7 = DP, bits 6:0 = g..a, all active-low.
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_BAD    = 8'h7F;  // DP only: marks an unsupported character
  localparam int         SEG_DP_BIT = 7;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [7:0] GLYPH_DASH = 8'hBF;
  localparam logic [7:0] GLYPH_0    = 8'hC0;
  localparam logic [7:0] GLYPH_1    = 8'hF9;
  localparam logic [7:0] GLYPH_2    = 8'hA4;
  localparam logic [7:0] GLYPH_3    = 8'hB0;
  localparam logic [7:0] GLYPH_4    = 8'h99;
  localparam logic [7:0] GLYPH_5    = 8'h92;
  localparam logic [7:0] GLYPH_6    = 8'h82;
  localparam logic [7:0] GLYPH_7    = 8'hF8;
  localparam logic [7:0] GLYPH_8    = 8'h80;
  localparam logic [7:0] GLYPH_9    = 8'h90;
  localparam logic [7:0] GLYPH_A    = 8'h88;
  localparam logic [7:0] GLYPH_B    = 8'h83;
  localparam logic [7:0] GLYPH_C_UP = 8'hC6;
  localparam logic [7:0] GLYPH_C_LO = 8'hA7;
  localparam logic [7:0] GLYPH_D    = 8'hA1;
  localparam logic [7:0] GLYPH_E    = 8'h86;
  localparam logic [7:0] GLYPH_F    = 8'h8E;
  localparam logic [7:0] GLYPH_G    = 8'hC2;
  localparam logic [7:0] GLYPH_H_UP = 8'h89;
  localparam logic [7:0] GLYPH_H_LO = 8'h8B;
  localparam logic [7:0] GLYPH_I_UP = 8'hF9;
  localparam logic [7:0] GLYPH_I_LO = 8'hFB;  // single segment c
  localparam logic [7:0] GLYPH_J    = 8'hE1;
  localparam logic [7:0] GLYPH_L    = 8'hC7;
  localparam logic [7:0] GLYPH_N    = 8'hAB;
  localparam logic [7:0] GLYPH_O_LO = 8'hA3;
  localparam logic [7:0] GLYPH_P    = 8'h8C;
  localparam logic [7:0] GLYPH_Q    = 8'h98;
  localparam logic [7:0] GLYPH_R    = 8'hAF;
  localparam logic [7:0] GLYPH_T    = 8'h87;
  localparam logic [7:0] GLYPH_U_UP = 8'hC1;
  localparam logic [7:0] GLYPH_U_LO = 8'hE3;
  localparam logic [7:0] GLYPH_Y    = 8'h91;

  typedef struct packed {
    logic [7:0] chr;
    logic       dp;
  } buf_entry_t;

  // Lights the decimal point (drives it low) on top of a looked-up glyph.
  function automatic logic [7:0] apply_dp(input logic [7:0] glyph, input logic dp);
    logic [7:0] r;
    r = glyph;
    if (dp) r[SEG_DP_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/seg_char_rom.sv
// rtl/seg_char_rom.sv - combinational ASCII to active-low 7-segment glyph lookup
// Ports: char_in [7:0] ASCII code in; seg_out [7:0] active-low segments out (DP off,
//        or DP-only for unsupported codes).
module seg_char_rom
  import seg_scan_driver_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [7:0] seg_out
);

  always_comb begin
    seg_out = SEG_BAD;
    case (char_in)
      8'h20:        seg_out = SEG_BLANK;
      8'h2D:        seg_out = GLYPH_DASH;
      8'h30:        seg_out = GLYPH_0;
      8'h31:        seg_out = GLYPH_1;
      8'h32:        seg_out = GLYPH_2;
      8'h33:        seg_out = GLYPH_3;
      8'h34:        seg_out = GLYPH_4;
      8'h35:        seg_out = GLYPH_5;
      8'h36:        seg_out = GLYPH_6;
      8'h37:        seg_out = GLYPH_7;
      8'h38:        seg_out = GLYPH_8;
      8'h39:        seg_out = GLYPH_9;
      8'h41, 8'h61: seg_out = GLYPH_A;
      8'h42, 8'h62: seg_out = GLYPH_B;
      8'h43:        seg_out = GLYPH_C_UP;
      8'h63:        seg_out = GLYPH_C_LO;
      8'h44, 8'h64: seg_out = GLYPH_D;
      8'h45, 8'h65: seg_out = GLYPH_E;
      8'h46, 8'h66: seg_out = GLYPH_F;
      8'h47, 8'h67: seg_out = GLYPH_G;
      8'h48:        seg_out = GLYPH_H_UP;
      8'h68:        seg_out = GLYPH_H_LO;
      8'h49:        seg_out = GLYPH_I_UP;
      8'h69:        seg_out = GLYPH_I_LO;
      8'h4A, 8'h6A: seg_out = GLYPH_J;
      8'h4C, 8'h6C: seg_out = GLYPH_L;
      8'h4E, 8'h6E: seg_out = GLYPH_N;
      8'h4F:        seg_out = GLYPH_0;
      8'h6F:        seg_out = GLYPH_O_LO;
      8'h50, 8'h70: seg_out = GLYPH_P;
      8'h51, 8'h71: seg_out = GLYPH_Q;
      8'h52, 8'h72: seg_out = GLYPH_R;
      8'h53, 8'h73: seg_out = GLYPH_5;
      8'h54, 8'h74: seg_out = GLYPH_T;
      8'h55:        seg_out = GLYPH_U_UP;
      8'h75:        seg_out = GLYPH_U_LO;
      8'h59, 8'h79: seg_out = GLYPH_Y;
      default:      seg_out = SEG_BAD;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment display driver with blanking, DP and blink
// Ports: clk, reset_n (sync, active-low); wr_en/wr_addr/wr_char/wr_dp character buffer
//        write; blink_mask per-digit blink; enable display on/off; seg active-low segments;
//        an active-low digit enables; frame_tick one-cycle pulse per scan frame.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 32,
  parameter int AW           = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              wr_dp,
  input  logic [DIGITS-1:0] blink_mask,
  input  logic              enable,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_tick
);

  localparam int PW = $clog2(PRESCALE);
  // +1 keeps the width at least one bit when BLINK_FRAMES is 1.
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DIGITS - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  buf_entry_t        buf_q [DIGITS];
  buf_entry_t        buf_d [DIGITS];
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_tick_q, frame_tick_d;

  logic       slot_end;
  logic       frame_end;
  buf_entry_t cur;
  logic [7:0] rom_seg;

  assign cur = buf_q[idx_q];

  seg_char_rom u_rom (
    .char_in (cur.chr),
    .seg_out (rom_seg)
  );

  always_comb begin
    slot_end  = (pcnt_q == PCNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;

    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Phase flips on the same edge that raises frame_tick for the qualifying frame.
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Out-of-range addresses (non power-of-two DIGITS) are dropped.
    buf_d = buf_q;
    if (wr_en && (32'(wr_addr) < 32'(DIGITS))) begin
      buf_d[wr_addr] = '{chr: wr_char, dp: wr_dp};
    end

    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = apply_dp(rom_seg, cur.dp);
    if (phase_q && blink_mask[idx_q]) seg_d = SEG_BLANK;
    // First cycle of every slot is dark so the previous digit's segments never ghost.
    if ((pcnt_q == '0) || !enable) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end

    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        buf_q[i] <= '{chr: CHAR_SPACE, dp: 1'b0};
      end
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
      buf_q        <= buf_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
